// File: rtl/board_led_scanner.sv
// Row-scanned driver for the 4x4 Connect-4 board on a bi-colour LED matrix.
// Each row gets a blanking gap followed by a drive window. The board is
// latched once per frame, just as row 0 is driven, so a frame never tears.
// Winning or drawn cells blink with a period set in whole frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | all rows and columns off; BLANK_CYCLES cycles before a row
//   ST_DRIVE | row_sel = 1 << row, columns from snapshot; CLK_DIV cycles
module board_led_scanner #(
  parameter int CLK_DIV      = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] gameboard,
  input  logic [15:0] player_cells,
  input  logic [1:0]  game_status,
  output logic [3:0]  row_sel,
  output logic [3:0]  col_p1,
  output logic [3:0]  col_p2,
  output logic        frame_start,
  output logic        blink_phase
);

  // The single cycle counter serves both states, so it is sized for the
  // longer of the two windows. It only ever reaches (length - 1).
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row;
  logic [FRM_W-1:0] frm_cnt;

  logic [15:0]      snap_board;
  logic [15:0]      snap_cells;
  logic [1:0]       snap_status;

  logic             frame_edge;
  logic             next_phase;
  logic [15:0]      src_board;
  logic [15:0]      src_cells;
  logic [1:0]       src_status;
  logic [3:0]       row_occ;
  logic [3:0]       row_own;
  logic [3:0]       p1_base;
  logic [3:0]       p2_base;
  logic [3:0]       p1_next;
  logic [3:0]       p2_next;

  // On the edge that starts row 0 the fresh inputs are latched and also used
  // directly, so row 0 of a new frame already reflects them; every other row
  // reads the frozen snapshot.
  always_comb begin
    frame_edge = (state == ST_BLANK) && (cnt == BLANK_LAST) && (row == 2'd0);
    next_phase = blink_phase;
    if (frame_edge && (frm_cnt == FRM_LAST)) begin
      next_phase = ~blink_phase;
    end

    src_board  = snap_board;
    src_cells  = snap_cells;
    src_status = snap_status;
    if (frame_edge) begin
      src_board  = gameboard;
      src_cells  = player_cells;
      src_status = game_status;
    end

    row_occ = src_board[{row, 2'b00} +: 4];
    row_own = src_cells[{row, 2'b00} +: 4];
    p1_base = row_occ & ~row_own;
    p2_base = row_occ & row_own;

    // status bit 0 marks player-1 cells as blinking, bit 1 player-2 cells;
    // a draw (11) sets both.
    p1_next = src_status[0] ? (p1_base & {4{next_phase}}) : p1_base;
    p2_next = src_status[1] ? (p2_base & {4{next_phase}}) : p2_base;
  end

  // Scan sequencer with registered row/column drive, frame marker and blink.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      row         <= 2'd0;
      frm_cnt     <= '0;
      snap_board  <= '0;
      snap_cells  <= '0;
      snap_status <= '0;
      row_sel     <= 4'b0000;
      col_p1      <= 4'b0000;
      col_p2      <= 4'b0000;
      frame_start <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state       <= ST_DRIVE;
            cnt         <= '0;
            row_sel     <= 4'b0001 << row;
            col_p1      <= p1_next;
            col_p2      <= p2_next;
            frame_start <= (row == 2'd0);
            if (row == 2'd0) begin
              snap_board  <= gameboard;
              snap_cells  <= player_cells;
              snap_status <= game_status;
              blink_phase <= next_phase;
              if (frm_cnt == FRM_LAST) begin
                frm_cnt <= '0;
              end else begin
                frm_cnt <= frm_cnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DRIVE: begin
          frame_start <= 1'b0;
          if (cnt == DRIVE_LAST) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            row     <= row + 2'd1;
            row_sel <= 4'b0000;
            col_p1  <= 4'b0000;
            col_p2  <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_led_scanner.sv
// Bench for board_led_scanner: a time-based model derives every output from
// the cycle index since reset and the board latched at each frame start.
module tb_board_led_scanner;

  localparam int DIV   = 4;
  localparam int BLK   = 2;
  localparam int BF    = 2;
  localparam int ROW_P = DIV + BLK;
  localparam int FRAME = 4 * ROW_P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gameboard = 16'h0000;
  logic [15:0] player_cells = 16'h0000;
  logic [1:0]  game_status = 2'b00;
  logic [3:0]  row_sel;
  logic [3:0]  col_p1;
  logic [3:0]  col_p2;
  logic        frame_start;
  logic        blink_phase;

  int n_checks = 0;
  int n_fail = 0;

  board_led_scanner #(
    .CLK_DIV(DIV),
    .BLANK_CYCLES(BLK),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gameboard(gameboard),
    .player_cells(player_cells),
    .game_status(game_status),
    .row_sel(row_sel),
    .col_p1(col_p1),
    .col_p2(col_p2),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  // Model time base: t is the index of the current cycle since reset release.
  int          t = 0;
  bit          started = 1'b0;
  logic [15:0] snap_b = 16'h0000;
  logic [15:0] snap_c = 16'h0000;
  logic [1:0]  snap_s = 2'b00;

  // Advance model time; latch the board on the edge that starts row 0.
  always @(posedge clk) begin
    if (reset) begin
      t = 0;
      started = 1'b1;
      snap_b = 16'h0000;
      snap_c = 16'h0000;
      snap_s = 2'b00;
    end else if (started) begin
      if ((t % FRAME) == (BLK - 1)) begin
        snap_b = gameboard;
        snap_c = player_cells;
        snap_s = game_status;
      end
      t = t + 1;
    end
  end

  function automatic void model(input int tt, input logic [15:0] b, input logic [15:0] c,
                                input logic [1:0] s, output logic [3:0] rs,
                                output logic [3:0] p1, output logic [3:0] p2,
                                output logic fs, output logic ph);
    int pos, r, k, nfs, idx;
    logic occ, own, show1, show2;
    pos = tt % FRAME;
    r = pos / ROW_P;
    k = pos % ROW_P;
    nfs = (tt >= BLK) ? ((tt - BLK) / FRAME + 1) : 0;
    ph = ((nfs / BF) % 2) == 1;
    fs = (r == 0) && (k == BLK);
    rs = 4'b0000;
    p1 = 4'b0000;
    p2 = 4'b0000;
    show1 = 1'b1;
    show2 = 1'b1;
    case (s)
      2'b01: show1 = ph;
      2'b10: show2 = ph;
      2'b11: begin show1 = ph; show2 = ph; end
      default: ;
    endcase
    if (k >= BLK) begin
      rs[r] = 1'b1;
      for (int col = 0; col < 4; col++) begin
        idx = r * 4 + col;
        occ = b[idx];
        own = c[idx];
        p1[col] = occ && !own && show1;
        p2[col] = occ && own && show2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [3:0] e_rs, e_p1, e_p2;
    logic e_fs, e_ph;
    if (started) begin
      model(t, snap_b, snap_c, snap_s, e_rs, e_p1, e_p2, e_fs, e_ph);
      chk("row_sel", {12'h0, row_sel}, {12'h0, e_rs});
      chk("col_p1", {12'h0, col_p1}, {12'h0, e_p1});
      chk("col_p2", {12'h0, col_p2}, {12'h0, e_p2});
      chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
      chk("blink_phase", {15'h0, blink_phase}, {15'h0, e_ph});
      chk("col_exclusive", {12'h0, col_p1 & col_p2}, 16'h0000);
      chk("row_onehot", {15'h0, ($countones(row_sel) > 1)}, 16'h0000);
    end
  end

  task automatic wait_t(input int target);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (t == target) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_t: cycle %0d never reached (t=%0d)", target, t);
  endtask

  initial begin
    reset = 1'b1;
    gameboard = 16'h0001;
    player_cells = 16'h0000;
    game_status = 2'b00;
    repeat (3) @(negedge clk);
    chk("lit_reset_rowsel", {12'h0, row_sel}, 16'h0000);
    chk("lit_reset_blink", {15'h0, blink_phase}, 16'h0000);
    reset = 1'b0;

    wait_t(1);
    chk("lit_t1_rowsel", {12'h0, row_sel}, 16'h0000);
    wait_t(2);
    chk("lit_t2_rowsel", {12'h0, row_sel}, 16'h0001);
    chk("lit_t2_fs", {15'h0, frame_start}, 16'h0001);
    chk("lit_t2_p1", {12'h0, col_p1}, 16'h0001);
    chk("lit_t2_p2", {12'h0, col_p2}, 16'h0000);
    wait_t(3);
    chk("lit_t3_fs", {15'h0, frame_start}, 16'h0000);
    wait_t(8);
    chk("lit_row1_sel", {12'h0, row_sel}, 16'h0002);
    chk("lit_row1_p1", {12'h0, col_p1}, 16'h0000);
    wait_t(14);
    chk("lit_row2_sel", {12'h0, row_sel}, 16'h0004);
    gameboard = 16'h0010;
    wait_t(20);
    chk("lit_row3_sel", {12'h0, row_sel}, 16'h0008);
    chk("lit_row3_p1", {12'h0, col_p1}, 16'h0000);
    wait_t(26);
    chk("lit_f2_fs", {15'h0, frame_start}, 16'h0001);
    chk("lit_f2_row0_p1", {12'h0, col_p1}, 16'h0000);
    chk("lit_f2_blink", {15'h0, blink_phase}, 16'h0001);
    wait_t(32);
    chk("lit_f2_row1_p1", {12'h0, col_p1}, 16'h0001);

    wait_t(40);
    gameboard = 16'h0021;
    player_cells = 16'h0020;
    game_status = 2'b01;
    wait_t(50);
    chk("lit_p1win_on", {12'h0, col_p1}, 16'h0001);
    wait_t(56);
    chk("lit_p1win_p2", {12'h0, col_p2}, 16'h0002);
    wait_t(74);
    chk("lit_p1win_blink0", {15'h0, blink_phase}, 16'h0000);
    chk("lit_p1win_off", {12'h0, col_p1}, 16'h0000);
    wait_t(80);
    chk("lit_p1win_p2_steady", {12'h0, col_p2}, 16'h0002);

    wait_t(90);
    game_status = 2'b11;
    wait_t(98);
    chk("lit_draw_p1_off", {12'h0, col_p1}, 16'h0000);
    wait_t(104);
    chk("lit_draw_p2_off", {12'h0, col_p2}, 16'h0000);
    wait_t(122);
    chk("lit_draw_p1_on", {12'h0, col_p1}, 16'h0001);
    chk("lit_draw_blink1", {15'h0, blink_phase}, 16'h0001);
    wait_t(128);
    chk("lit_draw_p2_on", {12'h0, col_p2}, 16'h0002);

    wait_t(135);
    chk("lit_pre_rst_sel", {12'h0, row_sel}, 16'h0004);
    reset = 1'b1;
    @(negedge clk);
    chk("lit_mid_rst_sel", {12'h0, row_sel}, 16'h0000);
    chk("lit_mid_rst_blink", {15'h0, blink_phase}, 16'h0000);
    chk("lit_mid_rst_p2", {12'h0, col_p2}, 16'h0000);
    reset = 1'b0;
    wait_t(1);
    chk("lit_rst2_t1_sel", {12'h0, row_sel}, 16'h0000);
    wait_t(2);
    chk("lit_rst2_t2_sel", {12'h0, row_sel}, 16'h0001);
    chk("lit_rst2_t2_fs", {15'h0, frame_start}, 16'h0001);
    chk("lit_rst2_t2_p1", {12'h0, col_p1}, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) gameboard = 16'($urandom);
      if ($urandom_range(0, 9) == 0) player_cells = 16'($urandom);
      if ($urandom_range(0, 29) == 0) game_status = 2'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
